// File: rtl/gerenciador_de_acesso.sv
// -----------------------------------------------------------------------------
// gerenciador_de_acesso
//
// Purpose
//   Arbitrates one shared resource between two request interfaces, driven by
//   the result of an external two-interface priority comparator. The winner is
//   granted the resource until it releases it or a session timeout expires.
//   The loser is parked in a one-entry pending slot. After the session ends and
//   one DRAIN cycle has passed, the parked user is served automatically.
//
// Parameters
//   TIMEOUT_CYCLES  maximum number of cycles a grant is held without release (>= 2)
//   CNT_W           width of the session counter; must hold TIMEOUT_CYCLES-1
//
// Optional feature macro
//   GRANT_COUNT_EN  when defined, adds grant_cnt0/grant_cnt1. These are 16-bit
//                   saturating counts of the sessions started per interface.
//
// Ports
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous reset, active low
//   req0, req1     in   level requests from interface 0 / 1
//   user0_code     in   user code on interface 0 (3'b000 = no user)
//   user1_code     in   user code on interface 1
//   prio_sel       in   comparator result: 10 if0 wins, 01 if1 wins, 11 tie, 00 none
//   loser_code     in   comparator's lower-priority user code
//   release_i      in   active session ends this cycle
//   grant0/grant1  out  resource granted to interface 0 / 1 (never both)
//   busy           out  grant0 | grant1
//   active_code    out  code of the granted user, 3'b000 when not granted
//   pending_valid  out  pending slot occupied
//   pending_code   out  parked user code, 3'b000 when empty
//   timeout        out  one-cycle pulse when a session is cut by timeout
//   error          out  one-cycle pulse when both request with prio_sel == 00
//   grant_cnt0/1   out  (GRANT_COUNT_EN only) sessions started per interface
// -----------------------------------------------------------------------------
module gerenciador_de_acesso #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [2:0]  user0_code,
    input  logic [2:0]  user1_code,
    input  logic [1:0]  prio_sel,
    input  logic [2:0]  loser_code,
    input  logic        release_i,
    output logic        grant0,
    output logic        grant1,
    output logic        busy,
    output logic [2:0]  active_code,
    output logic        pending_valid,
    output logic [2:0]  pending_code,
    output logic        timeout,
`ifdef GRANT_COUNT_EN
    output logic [15:0] grant_cnt0,
    output logic [15:0] grant_cnt1,
`endif
    output logic        error
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       active_code_q, active_code_d;
    logic             pend_valid_q, pend_valid_d;
    logic [2:0]       pend_code_q, pend_code_d;
    logic             pend_iface_q, pend_iface_d;   // 0: parked on if0, 1: parked on if1
    logic             timeout_q, timeout_d;
    logic             error_q, error_d;

    // Signals of the interface that does not hold the grant.
    logic             other_req;
    logic [2:0]       other_code;

    always_comb begin
        other_req  = (state_q == ST_GRANT0) ? req1 : req0;
        other_code = (state_q == ST_GRANT0) ? user1_code : user0_code;
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        active_code_d = active_code_q;
        pend_valid_d  = pend_valid_q;
        pend_code_d   = pend_code_q;
        pend_iface_d  = pend_iface_q;
        timeout_d     = 1'b0;
        error_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d         = '0;
                active_code_d = 3'b000;
                if (req0 && !req1) begin
                    // prio_sel is meaningless with a single requester.
                    state_d       = ST_GRANT0;
                    active_code_d = user0_code;
                end else if (req1 && !req0) begin
                    state_d       = ST_GRANT1;
                    active_code_d = user1_code;
                end else if (req0 && req1) begin
                    case (prio_sel)
                        2'b10: begin
                            state_d       = ST_GRANT0;
                            active_code_d = user0_code;
                            pend_valid_d  = 1'b1;
                            pend_code_d   = loser_code;
                            pend_iface_d  = 1'b1;
                        end
                        2'b01: begin
                            state_d       = ST_GRANT1;
                            active_code_d = user1_code;
                            pend_valid_d  = 1'b1;
                            pend_code_d   = loser_code;
                            pend_iface_d  = 1'b0;
                        end
                        2'b11: begin
                            // Tie: if0 wins. The comparator's loser output is
                            // not trusted on a tie, so park if1's own code.
                            state_d       = ST_GRANT0;
                            active_code_d = user0_code;
                            pend_valid_d  = 1'b1;
                            pend_code_d   = user1_code;
                            pend_iface_d  = 1'b1;
                        end
                        default: begin
                            error_d = 1'b1;
                        end
                    endcase
                end
            end

            ST_GRANT0, ST_GRANT1: begin
                // The non-granted side may queue up, even in the session's last cycle.
                if (!pend_valid_q && other_req) begin
                    pend_valid_d = 1'b1;
                    pend_code_d  = other_code;
                    pend_iface_d = (state_q == ST_GRANT0);
                end
                if (release_i) begin
                    // Release takes precedence over a timeout in the same cycle.
                    state_d       = ST_DRAIN;
                    cnt_d         = '0;
                    active_code_d = 3'b000;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = ST_DRAIN;
                    cnt_d         = '0;
                    active_code_d = 3'b000;
                    timeout_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_DRAIN: begin
                cnt_d = '0;
                if (pend_valid_q) begin
                    state_d       = pend_iface_q ? ST_GRANT1 : ST_GRANT0;
                    active_code_d = pend_code_q;
                    pend_valid_d  = 1'b0;
                    pend_code_d   = 3'b000;
                    pend_iface_d  = 1'b0;
                end else begin
                    state_d       = ST_IDLE;
                    active_code_d = 3'b000;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            active_code_q <= 3'b000;
            pend_valid_q  <= 1'b0;
            pend_code_q   <= 3'b000;
            pend_iface_q  <= 1'b0;
            timeout_q     <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            active_code_q <= active_code_d;
            pend_valid_q  <= pend_valid_d;
            pend_code_q   <= pend_code_d;
            pend_iface_q  <= pend_iface_d;
            timeout_q     <= timeout_d;
            error_q       <= error_d;
        end
    end

`ifdef GRANT_COUNT_EN
    logic [15:0] gcnt0_q, gcnt0_d;
    logic [15:0] gcnt1_q, gcnt1_d;

    // A session starts when the next state enters a GRANT state from outside it.
    always_comb begin
        gcnt0_d = gcnt0_q;
        gcnt1_d = gcnt1_q;
        if (state_d == ST_GRANT0 && state_q != ST_GRANT0 && gcnt0_q != 16'hFFFF) begin
            gcnt0_d = gcnt0_q + 16'd1;
        end
        if (state_d == ST_GRANT1 && state_q != ST_GRANT1 && gcnt1_q != 16'hFFFF) begin
            gcnt1_d = gcnt1_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gcnt0_q <= 16'd0;
            gcnt1_q <= 16'd0;
        end else begin
            gcnt0_q <= gcnt0_d;
            gcnt1_q <= gcnt1_d;
        end
    end

    assign grant_cnt0 = gcnt0_q;
    assign grant_cnt1 = gcnt1_q;
`endif

    // Every output is a decode of, or a copy of, a flop.
    assign grant0        = (state_q == ST_GRANT0);
    assign grant1        = (state_q == ST_GRANT1);
    assign busy          = (state_q == ST_GRANT0) || (state_q == ST_GRANT1);
    assign active_code   = active_code_q;
    assign pending_valid = pend_valid_q;
    assign pending_code  = pend_code_q;
    assign timeout       = timeout_q;
    assign error         = error_q;

endmodule

// File: tb/tb_gerenciador_de_acesso.sv
// -----------------------------------------------------------------------------
// tb_gerenciador_de_acesso
//
// Table-driven bench for gerenciador_de_acesso with TIMEOUT_CYCLES = 4.
// Each table row gives the inputs for one cycle and the outputs expected after
// the following rising edge. The expected record is queued when the row is
// driven and popped when the outputs are sampled.
// A hand-written sequence follows the table. It covers the asynchronous reset
// in the middle of a session and, when GRANT_COUNT_EN is defined, the
// per-interface session counters.
// -----------------------------------------------------------------------------
module tb_gerenciador_de_acesso;

    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic        req0, req1;
    logic [2:0]  user0_code, user1_code, loser_code;
    logic [1:0]  prio_sel;
    logic        release_i;
    logic        grant0, grant1, busy;
    logic [2:0]  active_code, pending_code;
    logic        pending_valid, timeout, error;
`ifdef GRANT_COUNT_EN
    logic [15:0] grant_cnt0, grant_cnt1;
`endif

    gerenciador_de_acesso #(
        .TIMEOUT_CYCLES(TO),
        .CNT_W(8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0         (req0),
        .req1         (req1),
        .user0_code   (user0_code),
        .user1_code   (user1_code),
        .prio_sel     (prio_sel),
        .loser_code   (loser_code),
        .release_i    (release_i),
        .grant0       (grant0),
        .grant1       (grant1),
        .busy         (busy),
        .active_code  (active_code),
        .pending_valid(pending_valid),
        .pending_code (pending_code),
        .timeout      (timeout),
`ifdef GRANT_COUNT_EN
        .grant_cnt0   (grant_cnt0),
        .grant_cnt1   (grant_cnt1),
`endif
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       g0;
        logic       g1;
        logic [2:0] act;
        logic       pv;
        logic [2:0] pc;
        logic       to;
        logic       er;
    } exp_t;

    typedef struct packed {
        logic       r0;
        logic       r1;
        logic [2:0] u0;
        logic [2:0] u1;
        logic [1:0] ps;
        logic [2:0] lc;
        logic       rel;
        exp_t       e;
    } vec_t;

    vec_t tbl[$];
    exp_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int row, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic add(input logic r0, input logic r1, input logic [2:0] u0, input logic [2:0] u1,
                       input logic [1:0] ps, input logic [2:0] lc, input logic rel,
                       input logic g0, input logic g1, input logic [2:0] act, input logic pv,
                       input logic [2:0] pc, input logic to, input logic er);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.u0 = u0; v.u1 = u1; v.ps = ps; v.lc = lc; v.rel = rel;
        v.e.g0 = g0; v.e.g1 = g1; v.e.act = act; v.e.pv = pv; v.e.pc = pc;
        v.e.to = to; v.e.er = er;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r0, input logic r1, input logic [2:0] u0, input logic [2:0] u1,
                         input logic [1:0] ps, input logic [2:0] lc, input logic rel);
        req0 = r0; req1 = r1; user0_code = u0; user1_code = u1;
        prio_sel = ps; loser_code = lc; release_i = rel;
    endtask

    task automatic check_outputs(input int row, input exp_t e);
        check("grant0",        row, 16'(grant0),        16'(e.g0));
        check("grant1",        row, 16'(grant1),        16'(e.g1));
        check("busy",          row, 16'(busy),          16'(e.g0 | e.g1));
        check("active_code",   row, 16'(active_code),   16'(e.act));
        check("pending_valid", row, 16'(pending_valid), 16'(e.pv));
        check("pending_code",  row, 16'(pending_code),  16'(e.pc));
        check("timeout",       row, 16'(timeout),       16'(e.to));
        check("error",         row, 16'(error),         16'(e.er));
    endtask

    // One cycle of a hand-written sequence: drive, clock, compare.
    task automatic step(input int row, input logic r0, input logic r1, input logic [2:0] u0,
                        input logic [2:0] u1, input logic [1:0] ps, input logic [2:0] lc,
                        input logic rel, input exp_t e);
        drive(r0, r1, u0, u1, ps, lc, rel);
        @(posedge clk); #1;
        check_outputs(row, e);
        $display("seq %0d: g0=%0b g1=%0b act=%0d pv=%0b pc=%0d to=%0b err=%0b", row,
                 grant0, grant1, active_code, pending_valid, pending_code, timeout, error);
    endtask

    exp_t zero_e;

    initial begin
        zero_e = '0;
        //   r0 r1 u0 u1 ps     lc rel | g0 g1 act pv pc to er
        // Both request, if0 wins: if1's loser code is parked, then served after DRAIN.
        add(1, 1, 6, 3, 2'b10, 3, 0,   1, 0, 6, 1, 3, 0, 0);
        add(0, 0, 6, 3, 2'b10, 3, 1,   0, 0, 0, 1, 3, 0, 0);
        add(0, 0, 0, 0, 2'b00, 0, 0,   0, 1, 3, 0, 0, 0, 0);
        add(0, 0, 0, 0, 2'b00, 0, 1,   0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 2'b00, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        // Only req1 held: 4 granted cycles, then timeout with DRAIN, IDLE, regrant.
        add(0, 1, 0, 5, 2'b00, 0, 0,   0, 1, 5, 0, 0, 0, 0);
        add(0, 1, 0, 5, 2'b00, 0, 0,   0, 1, 5, 0, 0, 0, 0);
        add(0, 1, 0, 5, 2'b00, 0, 0,   0, 1, 5, 0, 0, 0, 0);
        add(0, 1, 0, 5, 2'b00, 0, 0,   0, 1, 5, 0, 0, 0, 0);
        add(0, 1, 0, 5, 2'b00, 0, 0,   0, 0, 0, 0, 0, 1, 0);
        add(0, 1, 0, 5, 2'b00, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 5, 2'b00, 0, 0,   0, 1, 5, 0, 0, 0, 0);
        // Release in the last allowed cycle beats the timeout.
        add(0, 0, 0, 5, 2'b00, 0, 0,   0, 1, 5, 0, 0, 0, 0);
        add(0, 0, 0, 5, 2'b00, 0, 0,   0, 1, 5, 0, 0, 0, 0);
        add(0, 0, 0, 5, 2'b00, 0, 0,   0, 1, 5, 0, 0, 0, 0);
        add(0, 0, 0, 5, 2'b00, 0, 1,   0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 2'b00, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        // No comparator decision gives an error; then a tie parks user1_code, not loser_code.
        add(1, 1, 6, 3, 2'b00, 0, 0,   0, 0, 0, 0, 0, 0, 1);
        add(1, 1, 6, 3, 2'b11, 1, 0,   1, 0, 6, 1, 3, 0, 0);
        add(0, 0, 0, 0, 2'b00, 0, 1,   0, 0, 0, 1, 3, 0, 0);
        add(0, 0, 0, 0, 2'b00, 0, 0,   0, 1, 3, 0, 0, 0, 0);
        // if0 requests while if1 is granted and the slot is empty: parked.
        add(1, 0, 2, 0, 2'b00, 0, 0,   0, 1, 3, 1, 2, 0, 0);
        add(0, 0, 2, 0, 2'b00, 0, 1,   0, 0, 0, 1, 2, 0, 0);
        add(0, 0, 0, 0, 2'b00, 0, 0,   1, 0, 2, 0, 0, 0, 0);
        add(0, 0, 0, 0, 2'b00, 0, 1,   0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 2'b00, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        // if1 wins.
        add(1, 1, 4, 7, 2'b01, 4, 0,   0, 1, 7, 1, 4, 0, 0);
        add(0, 0, 4, 7, 2'b01, 4, 1,   0, 0, 0, 1, 4, 0, 0);
        add(0, 0, 0, 0, 2'b00, 0, 0,   1, 0, 4, 0, 0, 0, 0);
        add(0, 0, 0, 0, 2'b00, 0, 1,   0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 2'b00, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        // Release while idle is ignored; a single requester ignores prio_sel.
        add(0, 0, 0, 0, 2'b00, 0, 1,   0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 2'b01, 0, 0,   1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 2'b00, 0, 1,   0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 2'b00, 0, 0,   0, 0, 0, 0, 0, 0, 0);

        // Reset state
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 2'b00, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_outputs(-1, zero_e);
`ifdef GRANT_COUNT_EN
        check("grant_cnt0_reset", -1, grant_cnt0, 16'd0);
        check("grant_cnt1_reset", -1, grant_cnt1, 16'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            exp_t e;
            drive(tbl[i].r0, tbl[i].r1, tbl[i].u0, tbl[i].u1, tbl[i].ps, tbl[i].lc, tbl[i].rel);
            sb_q.push_back(tbl[i].e);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            check_outputs(i, e);
            check("grant_exclusive", i, 16'(grant0 & grant1), 16'd0);
            $display("row %0d: r0=%0b r1=%0b ps=%0b rel=%0b -> g0=%0b g1=%0b act=%0d pv=%0b pc=%0d to=%0b err=%0b",
                     i, tbl[i].r0, tbl[i].r1, tbl[i].ps, tbl[i].rel, grant0, grant1,
                     active_code, pending_valid, pending_code, timeout, error);
        end
        check("scoreboard_drained", -1, 16'(sb_q.size()), 16'd0);

`ifdef GRANT_COUNT_EN
        check("grant_cnt0_table", -1, grant_cnt0, 16'd5);
        check("grant_cnt1_table", -1, grant_cnt1, 16'd5);
`endif

        // Asynchronous reset in the middle of GRANT0 with the pending slot set.
        begin
            exp_t e;
            e = '0; e.g0 = 1; e.act = 6; e.pv = 1; e.pc = 3;
            step(100, 1, 1, 6, 3, 2'b10, 3, 0, e);
            step(101, 0, 0, 0, 0, 2'b00, 0, 0, e);
            #2;
            rst_n = 1'b0;
            #1;
            check_outputs(102, zero_e);
            @(posedge clk); #1;
            check_outputs(103, zero_e);
            @(negedge clk);
            rst_n = 1'b1;
            // Back in IDLE: a single req1 is granted after one edge.
            e = '0; e.g1 = 1; e.act = 5;
            step(104, 0, 1, 0, 5, 2'b00, 0, 0, e);
        end

`ifdef GRANT_COUNT_EN
        // One if1 session (above), then three if0 sessions.
        begin
            exp_t e;
            step(105, 0, 0, 0, 0, 2'b00, 0, 1, zero_e);
            step(106, 0, 0, 0, 0, 2'b00, 0, 0, zero_e);
            for (int k = 0; k < 3; k++) begin
                e = '0; e.g0 = 1; e.act = 2;
                step(110 + 3 * k, 1, 0, 2, 0, 2'b00, 0, 0, e);
                step(111 + 3 * k, 0, 0, 0, 0, 2'b00, 0, 1, zero_e);
                step(112 + 3 * k, 0, 0, 0, 0, 2'b00, 0, 0, zero_e);
            end
            check("grant_cnt0_after", -1, grant_cnt0, 16'd3);
            check("grant_cnt1_after", -1, grant_cnt1, 16'd1);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Absolute bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
